// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage and general-purpose register file.
//
// Takes the registered result bundle from the M stage and commits it to the
// register file using byte-lane write enables. These enables also carry the
// partial merges for lwl/lwr.
//
// Decode gets two combinational read ports. Each read port bypasses the
// in-flight write per byte lane, so decode sees the M result with no latency.
//
// A retired-instruction counter counts committed bundles. A stalled M stage
// re-presents the same bundle, and the counter still counts that bundle once.
//
// Optional feature: define WB_DEBUG_TRACE_EN to build the registered commit
// trace (debug_* ports). When it is left undefined, all debug_* ports are
// tied to zero and no trace flops are built.

module wb_regfile #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             dm_stall,
  input  logic [3:0]       M_WriteRegEnableExted,
  input  logic [4:0]       M_RegId,
  input  logic [31:0]      M_Data,
  input  logic [31:0]      M_PC,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  output logic [31:0]      rs_data,
  output logic [31:0]      rt_data,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  // Replace the enabled byte lanes of 'old' with the matching lanes of 'data'.
  function automatic logic [31:0] f_merge(input logic [31:0] old,
                                          input logic [3:0]  lanes,
                                          input logic [31:0] data);
    logic [31:0] v;
    v = old;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) v[8*i +: 8] = data[8*i +: 8];
    end
    return v;
  endfunction

  logic [31:0]      r_rf [NREG];
  logic             r_fresh;
  logic [CNT_W-1:0] r_retired_cnt;

  logic             w_id_valid;
  logic             w_rf_we;
  logic [AW-1:0]    w_wr_idx;
  logic [31:0]      w_wb_new;
  logic             w_commit;
  logic             w_rs_valid;
  logic             w_rt_valid;
  logic [3:0]       w_rs_hit;
  logic [3:0]       w_rt_hit;

  // Write-side decode: target register, merged post-write value, commit strobe.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    w_id_valid = (M_RegId != '0) && (int'(M_RegId) < NREG);
    w_wr_idx   = M_RegId[AW-1:0];
    w_rf_we    = w_id_valid && (M_WriteRegEnableExted != '0);
    w_wb_new   = '0;
    if (w_id_valid) w_wb_new = f_merge(r_rf[w_wr_idx], M_WriteRegEnableExted, M_Data);
    w_commit   = r_fresh && (M_PC != '0);
  end

  // fresh marks the first cycle the M bundle is new; stalls re-present it without re-committing.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    if (Clr) r_fresh <= 1'b0;
    else     r_fresh <= !dm_stall;
  end

  // Register file: byte-lane commit. A repeated write under stall is harmless and is not gated by fresh.
  always_ff @(posedge Clk) begin
    // NOTE: the array is deliberately reset entry by entry because Clr must zero every GPR in one cycle; this keeps it in flops rather than RAM.
    if (Clr) begin
      for (int k = 0; k < NREG; k++) r_rf[k] <= '0;
    end else if (w_rf_we) begin
      r_rf[w_wr_idx] <= w_wb_new;
    end
  end

  // Retired-instruction counter; wraps silently at 2^CNT_W.
  always_ff @(posedge Clk) begin
    if (Clr)           r_retired_cnt <= '0;
    else if (w_commit) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
  end

  assign retired_cnt = r_retired_cnt;

  // Read ports: register 0 (and ids beyond NREG) read zero; bypass the M write lane by lane.
  always_comb begin
    w_rs_valid = (rs_id != '0) && (int'(rs_id) < NREG);
    w_rt_valid = (rt_id != '0) && (int'(rt_id) < NREG);
    w_rs_hit   = (rs_id == M_RegId) ? M_WriteRegEnableExted : 4'b0000;
    w_rt_hit   = (rt_id == M_RegId) ? M_WriteRegEnableExted : 4'b0000;
    rs_data    = '0;
    rt_data    = '0;
    if (w_rs_valid) rs_data = f_merge(r_rf[rs_id[AW-1:0]], w_rs_hit, M_Data);
    if (w_rt_valid) rt_data = f_merge(r_rf[rt_id[AW-1:0]], w_rt_hit, M_Data);
  end

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] r_dbg_pc;
  logic [3:0]  r_dbg_wen;
  logic [4:0]  r_dbg_wnum;
  logic [31:0] r_dbg_wdata;

  // Commit trace: one registered pulse per committed instruction; PC/num/data hold between pulses.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_dbg_pc    <= '0;
      r_dbg_wen   <= '0;
      r_dbg_wnum  <= '0;
      r_dbg_wdata <= '0;
    end else if (w_commit) begin
      r_dbg_pc    <= M_PC;
      r_dbg_wen   <= M_WriteRegEnableExted & {4{M_RegId != '0}};
      r_dbg_wnum  <= M_RegId;
      r_dbg_wdata <= w_wb_new;
    end else begin
      r_dbg_wen   <= '0;
    end
  end

  assign debug_wb_pc       = r_dbg_pc;
  assign debug_wb_rf_wen   = r_dbg_wen;
  assign debug_wb_rf_wnum  = r_dbg_wnum;
  assign debug_wb_rf_wdata = r_dbg_wdata;
`else
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- scoreboard bench for wb_regfile.
//
// Every cycle the driver applies a bundle and pushes the expected outputs,
// taken from a behavioural model, into a queue. A separate monitor pops and
// compares these on the falling edge.
//
// The DUT is built with CNT_W = 4, so counter wrap-around is reached quickly.

module tb_wb_regfile;

  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Clr;
  logic             dm_stall;
  logic [3:0]       wen;
  logic [4:0]       rid;
  logic [31:0]      mdata;
  logic [31:0]      mpc;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic [CNT_W-1:0] retired_cnt;
  logic [31:0]      debug_wb_pc;
  logic [3:0]       debug_wb_rf_wen;
  logic [4:0]       debug_wb_rf_wnum;
  logic [31:0]      debug_wb_rf_wdata;

  always #5 Clk = ~Clk;

  wb_regfile #(.NREG(32), .CNT_W(CNT_W)) dut (
    .Clk                   (Clk),
    .Clr                   (Clr),
    .dm_stall              (dm_stall),
    .M_WriteRegEnableExted (wen),
    .M_RegId               (rid),
    .M_Data                (mdata),
    .M_PC                  (mpc),
    .rs_id                 (rs_id),
    .rt_id                 (rt_id),
    .rs_data               (rs_data),
    .rt_data               (rt_data),
    .retired_cnt           (retired_cnt),
    .debug_wb_pc           (debug_wb_pc),
    .debug_wb_rf_wen       (debug_wb_rf_wen),
    .debug_wb_rf_wnum      (debug_wb_rf_wnum),
    .debug_wb_rf_wdata     (debug_wb_rf_wdata)
  );

  typedef struct {
    string       tag;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] cnt;
    logic [31:0] dpc;
    logic [31:0] dwen;
    logic [31:0] dnum;
    logic [31:0] ddata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: architectural state plus the "new bundle in M" notion.
  logic [31:0] m_rf [32];
  int unsigned m_cnt   = 0;
  bit          m_new   = 1'b0;
  logic [31:0] m_tpc   = '0;
  logic [3:0]  m_twen  = '0;
  logic [4:0]  m_tnum  = '0;
  logic [31:0] m_tdata = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Architectural effect of the clock edge that just happened, using the inputs held across it.
  task automatic model_step();
    bit commit;
    commit = m_new && (mpc != 0);
    if (Clr) begin
      foreach (m_rf[k]) m_rf[k] = '0;
      m_cnt   = 0;
      m_tpc   = '0;
      m_twen  = '0;
      m_tnum  = '0;
      m_tdata = '0;
    end else begin
      if (rid != 0)
        for (int i = 0; i < 4; i++)
          if (wen[i]) m_rf[rid][8*i +: 8] = mdata[8*i +: 8];
      if (commit) begin
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        m_tpc   = mpc;
        m_twen  = (rid != 0) ? wen : 4'h0;
        m_tnum  = rid;
        m_tdata = m_rf[rid];
      end else begin
        m_twen  = '0;
      end
    end
    // A bundle is new in the next cycle only if M was free to advance in this one.
    m_new = !Clr && !dm_stall;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] id);
    logic [31:0] v;
    if (id == 0) return 32'h0;
    v = m_rf[id];
    if (id == rid)
      for (int i = 0; i < 4; i++)
        if (wen[i]) v[8*i +: 8] = mdata[8*i +: 8];
    return v;
  endfunction

  task automatic cycle(input string tag, input bit clr, input bit stall,
                       input logic [3:0] w, input logic [4:0] id,
                       input logic [31:0] d, input logic [31:0] pc,
                       input logic [4:0] a, input logic [4:0] b);
    exp_t e;
    @(posedge Clk);
    model_step();
    #1;
    Clr = clr; dm_stall = stall; wen = w; rid = id; mdata = d; mpc = pc;
    rs_id = a; rt_id = b;
    e.tag = tag;
    e.rs  = model_read(a);
    e.rt  = model_read(b);
    e.cnt = m_cnt;
`ifdef WB_DEBUG_TRACE_EN
    e.dpc   = m_tpc;
    e.dwen  = 32'(m_twen);
    e.dnum  = 32'(m_tnum);
    e.ddata = m_tdata;
`else
    e.dpc   = '0;
    e.dwen  = '0;
    e.dnum  = '0;
    e.ddata = '0;
`endif
    sb.push_back(e);
  endtask

  task automatic idle(input string tag, input logic [4:0] a, input logic [4:0] b);
    cycle(tag, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 32'h0, a, b);
  endtask

  // Monitor: every output is presented every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".rs_data"}, rs_data, e.rs);
        check({e.tag, ".rt_data"}, rt_data, e.rt);
        check({e.tag, ".retired_cnt"}, 32'(retired_cnt), e.cnt);
        check({e.tag, ".dbg_pc"}, debug_wb_pc, e.dpc);
        check({e.tag, ".dbg_wen"}, 32'(debug_wb_rf_wen), e.dwen);
        check({e.tag, ".dbg_wnum"}, 32'(debug_wb_rf_wnum), e.dnum);
        check({e.tag, ".dbg_wdata"}, debug_wb_rf_wdata, e.ddata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  w;
    logic [4:0]  id, a, b;
    logic [31:0] d, pc;
    bit          st, clr, prev_st;

    Clr = 1'b1; dm_stall = 1'b0; wen = '0; rid = '0; mdata = '0; mpc = '0;
    rs_id = '0; rt_id = '0;
    foreach (m_rf[k]) m_rf[k] = '0;

    // Reset held for two cycles, then every register reads zero.
    cycle("reset", 1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd1);
    cycle("reset", 1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 5'd2, 5'd3);
    for (int i = 0; i < 16; i++) idle("read_all", 5'(2*i), 5'(2*i + 1));

    // Full-word write with same-cycle bypass, then read back from the file.
    cycle("wr5", 1'b0, 1'b0, 4'hF, 5'd5, 32'h12345678, 32'hBFC00000, 5'd5, 5'd5);
    idle("rd5", 5'd5, 5'd0);

    // lwr-style partial merge into an existing value.
    cycle("wr7", 1'b0, 1'b0, 4'hF, 5'd7, 32'hAABBCCDD, 32'hBFC00004, 5'd0, 5'd7);
    cycle("lwr7", 1'b0, 1'b0, 4'b0011, 5'd7, 32'h00001122, 32'hBFC00008, 5'd7, 5'd7);
    idle("rd7", 5'd5, 5'd7);
    cycle("lwl7", 1'b0, 1'b0, 4'b1100, 5'd7, 32'h99880000, 32'hBFC0000C, 5'd7, 5'd5);
    idle("rd7b", 5'd7, 5'd7);

    // Register 0 stays zero but the instruction still retires.
    cycle("wr0", 1'b0, 1'b0, 4'hF, 5'd0, 32'hFFFFFFFF, 32'hBFC00010, 5'd0, 5'd0);
    idle("rd0", 5'd0, 5'd5);

    // Bundle held by a three-cycle stall retires exactly once.
    for (int i = 0; i < 4; i++)
      cycle("stall", 1'b0, (i < 3), 4'hF, 5'd9, 32'hCAFEF00D, 32'h80000010, 5'd9, 5'd7);
    idle("post_stall", 5'd9, 5'd0);
    idle("post_stall", 5'd9, 5'd0);

    // Counter wrap: many commits without register writes.
    for (int i = 0; i < 18; i++)
      cycle("wrap", 1'b0, 1'b0, 4'h0, 5'd3, 32'h0, 32'h90000000 + 32'(4*i), 5'd5, 5'd9);
    idle("wrap_end", 5'd5, 5'd9);

    // Reset arriving mid-stall overrides the held write; later bundles commit once.
    cycle("rst_stall", 1'b0, 1'b1, 4'hF, 5'd11, 32'h11111111, 32'h80000020, 5'd11, 5'd5);
    cycle("rst_stall", 1'b1, 1'b1, 4'hF, 5'd11, 32'h11111111, 32'h80000020, 5'd5, 5'd9);
    cycle("rst_stall", 1'b0, 1'b1, 4'hF, 5'd11, 32'h11111111, 32'h80000020, 5'd11, 5'd9);
    cycle("rst_stall", 1'b0, 1'b0, 4'hF, 5'd11, 32'h11111111, 32'h80000020, 5'd11, 5'd5);
    cycle("post_rst", 1'b0, 1'b0, 4'hF, 5'd12, 32'h22222222, 32'h80000024, 5'd11, 5'd12);
    idle("post_rst", 5'd12, 5'd11);

    // Randomised traffic; stalled bundles are re-presented unchanged.
    prev_st = 1'b0;
    w = '0; id = '0; d = '0; pc = '0;
    for (int n = 0; n < 400; n++) begin
      clr = ($urandom_range(99) == 0);
      if (!prev_st || clr) begin
        w  = 4'($urandom);
        id = 5'($urandom);
        d  = $urandom;
        pc = ($urandom_range(3) == 0) ? 32'h0 : ($urandom | 32'h4);
        if (pc == 0) w = 4'h0;
      end
      st = ($urandom_range(3) == 0);
      a  = ($urandom_range(1) == 0) ? id : 5'($urandom);
      b  = ($urandom_range(2) == 0) ? id : 5'($urandom);
      cycle("rand", clr, st, w, id, d, pc, a, b);
      prev_st = st && !clr;
    end
    idle("drain", 5'd1, 5'd2);

    @(negedge Clk);
    @(negedge Clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
